// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache/dcache request ports and the shared RAM port around cache_mem_arbiter.
// master: the arbiter side; slave: the caches plus the memory model.
interface cache_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  grant;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache: dcache-priority registered grant
// FSM with a starvation guard that forces an icache grant after STARVE_LIMIT losses.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  cache_mem_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic ireq, dreq, ram_done;

  assign ireq     = bus.iREN;
  assign dreq     = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.grant    = state;

    unique case (state)
      IDLE: begin
        if (ireq && cnt >= CNT_W'(STARVE_LIMIT)) begin
          state_nxt = IGNT;
          cnt_nxt   = '0;
        end else if (dreq) begin
          state_nxt = DGNT;
          if (!ireq)
            cnt_nxt = '0;
          else if (cnt < CNT_W'(STARVE_LIMIT))
            cnt_nxt = cnt + 1'b1;
        end else if (ireq) begin
          state_nxt = IGNT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = '0;
        end
      end

      IGNT: begin
        // A dropped request gates the RAM port to zero and suppresses completion.
        if (ireq) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (ram_done) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      DGNT: begin
        if (dreq) begin
          bus.ramREN   = bus.dREN;
          bus.ramWEN   = bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (ram_done) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, single read, priority, starvation,
// abort, ERROR retry and asynchronous reset mid-grant.
module tb_cache_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   nerr = 0;
  int   nchk = 0;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = 2'd0;

    // 1. Reset held while requests toggle
    bus.iREN = 1'b1; bus.dWEN = 1'b1; bus.ramstate = 2'd2;
    tick(); tick();
    bus.iREN = 1'b0;
    tick();
    #1;
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_iwait",  32'(bus.iwait),  32'd1);
    chk("rst_dwait",  32'(bus.dwait),  32'd1);
    chk("rst_grant",  32'(bus.grant),  32'd0);
    chk("rst_iload",  bus.iload,       32'd0);
    bus.dWEN = 1'b0; bus.ramstate = 2'd0;
    #2 nRST = 1'b1;
    tick();

    // 2. Single icache read, RAM BUSY two cycles then ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = 2'd1; bus.ramload = 32'hDEADBEEF;
    #1;
    chk("rd_c0_grant",  32'(bus.grant),  32'd0);
    chk("rd_c0_ramREN", 32'(bus.ramREN), 32'd0);
    tick(); #1;
    chk("rd_c1_grant",   32'(bus.grant),  32'd1);
    chk("rd_c1_ramREN",  32'(bus.ramREN), 32'd1);
    chk("rd_c1_ramaddr", bus.ramaddr,     32'h100);
    chk("rd_c1_iwait",   32'(bus.iwait),  32'd1);
    chk("rd_c1_iload",   bus.iload,       32'd0);
    tick(); #1;
    chk("rd_c2_iwait",   32'(bus.iwait),  32'd1);
    bus.ramstate = 2'd2;
    #1;
    chk("rd_c3_iwait", 32'(bus.iwait), 32'd0);
    chk("rd_c3_iload", bus.iload,      32'hDEADBEEF);
    chk("rd_c3_dwait", 32'(bus.dwait), 32'd1);
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'd0;
    #1;
    chk("rd_c4_grant", 32'(bus.grant), 32'd0);
    chk("rd_c4_iwait", 32'(bus.iwait), 32'd1);

    // 3. Simultaneous requests: dcache write wins, then bubble, then icache
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678; bus.ramstate = 2'd1;
    tick(); #1;
    chk("sim_d_grant",    32'(bus.grant),  32'd2);
    chk("sim_d_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("sim_d_ramREN",   32'(bus.ramREN), 32'd0);
    chk("sim_d_ramstore", bus.ramstore,    32'h12345678);
    chk("sim_d_ramaddr",  bus.ramaddr,     32'h200);
    chk("sim_d_iwait",    32'(bus.iwait),  32'd1);
    bus.ramstate = 2'd2;
    #1;
    chk("sim_d_dwait", 32'(bus.dwait), 32'd0);
    chk("sim_d_iwait2", 32'(bus.iwait), 32'd1);
    tick();
    bus.dWEN = 1'b0; bus.ramstate = 2'd1;
    #1;
    chk("sim_bubble_grant",  32'(bus.grant),  32'd0);
    chk("sim_bubble_ramREN", 32'(bus.ramREN), 32'd0);
    tick(); #1;
    chk("sim_i_grant",   32'(bus.grant), 32'd1);
    chk("sim_i_ramaddr", bus.ramaddr,    32'h300);
    bus.ramstate = 2'd2;
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'd0;
    #1;

    // 4. Starvation: four dcache grants, then forced icache grant
    bus.iREN = 1'b1; bus.iaddr = 32'h700; bus.dREN = 1'b1; bus.daddr = 32'h1000;
    bus.ramstate = 2'd2; bus.ramload = 32'h0000_0055;
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("stv_idle%0d_grant", k), 32'(bus.grant), 32'd0);
      tick(); #1;
      chk($sformatf("stv_d%0d_grant", k),   32'(bus.grant), 32'd2);
      chk($sformatf("stv_d%0d_ramaddr", k), bus.ramaddr,    32'h1000 + 32'(k) * 32'd4);
      chk($sformatf("stv_d%0d_dwait", k),   32'(bus.dwait), 32'd0);
      tick();
      bus.daddr = bus.daddr + 32'd4;
    end
    #1;
    chk("stv_idle4_grant", 32'(bus.grant), 32'd0);
    tick(); #1;
    chk("stv_forced_grant", 32'(bus.grant), 32'd1);
    chk("stv_forced_iwait", 32'(bus.iwait), 32'd0);
    chk("stv_forced_dwait", 32'(bus.dwait), 32'd1);
    chk("stv_forced_iload", bus.iload,      32'h0000_0055);
    tick(); #1;
    chk("stv_after_grant", 32'(bus.grant), 32'd0);
    tick(); #1;
    chk("stv_cleared_grant", 32'(bus.grant), 32'd2);
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd0;
    tick();

    // 5a. Abort: dcache drops its read before ACCESS
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = 2'd1;
    tick(); #1;
    chk("abt_grant",  32'(bus.grant),  32'd2);
    chk("abt_ramREN", 32'(bus.ramREN), 32'd1);
    bus.dREN = 1'b0;
    #1;
    chk("abt_ramREN_drop",  32'(bus.ramREN), 32'd0);
    chk("abt_ramaddr_drop", bus.ramaddr,     32'd0);
    chk("abt_dwait",        32'(bus.dwait),  32'd1);
    tick(); #1;
    chk("abt_idle_grant", 32'(bus.grant), 32'd0);

    // 5b. ERROR for three cycles, then ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = 2'd3; bus.ramload = 32'hCAFEF00D;
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); #1;
      chk($sformatf("err%0d_grant", k), 32'(bus.grant), 32'd1);
      chk($sformatf("err%0d_iwait", k), 32'(bus.iwait), 32'd1);
      chk($sformatf("err%0d_iload", k), bus.iload,      32'd0);
    end
    bus.ramstate = 2'd2;
    #1;
    chk("err_done_iwait", 32'(bus.iwait), 32'd0);
    chk("err_done_iload", bus.iload,      32'hCAFEF00D);
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'd0;
    #1;
    chk("err_idle_grant", 32'(bus.grant), 32'd0);

    // 6. Asynchronous reset pulse in the middle of a dcache grant
    bus.dREN = 1'b1; bus.daddr = 32'h600; bus.ramstate = 2'd1;
    tick(); #1;
    chk("ar_pre_grant", 32'(bus.grant), 32'd2);
    #1 nRST = 1'b0;
    #1;
    chk("ar_ramREN", 32'(bus.ramREN), 32'd0);
    chk("ar_ramaddr", bus.ramaddr,    32'd0);
    chk("ar_grant",  32'(bus.grant),  32'd0);
    chk("ar_dwait",  32'(bus.dwait),  32'd1);
    nRST = 1'b1;
    #1;
    chk("ar_rel_grant", 32'(bus.grant), 32'd0);
    tick(); #1;
    chk("ar_rearb_grant",   32'(bus.grant), 32'd2);
    chk("ar_rearb_ramaddr", bus.ramaddr,    32'h600);
    bus.ramstate = 2'd2;
    #1;
    chk("ar_rearb_dwait", 32'(bus.dwait), 32'd0);
    tick();
    bus.dREN = 1'b0; bus.ramstate = 2'd0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
